bcd_entry_cgrundey: RTL and testbench
=====================================

# bcd_entry_cgrundey

Two-digit BCD entry stage that sits directly upstream of the 6-bit BCD-to-binary converter. It accepts decimal digits one at a time (tens, then units) over a valid/ready handshake, range-checks them, and packs each accepted pair into the 6-bit BCD word {tens[1:0], units[3:0]} the converter consumes. Packed words pass through a 2-entry output buffer with their own valid/ready handshake. Malformed entries and stalled entries are reported on an error pulse.

## Interface
- MAX_TENS, 3: largest legal tens digit. Must be ≤ 3, because the tens field is 2 bits wide.
- TIMEOUT, 15: cycles allowed in WAIT_UNITS with no digit accepted before the entry is aborted. Must be ≥ 1.

- clk  in  1  rising-edge clock
- rst_n  in  1  reset; asynchronous, active-low
- g_n  in  1  active-low group enable. When high: digit_ready = 0, any partial entry is flushed to IDLE, and the output buffer is unaffected.
- digit_in  in  4  BCD digit
- digit_valid  in  1  digit_in is valid
- digit_ready  out  1  stage accepts a digit
- bcd_out  out  6  packed BCD word, head of the buffer
- bcd_valid  out  1  bcd_out is valid
- bcd_ready  in  1  downstream converter accepts the word
- err  out  1  one-cycle error pulse
- err_code  out  2  error code: 01 = digit > 9; 10 = tens > MAX_TENS; 11 = timeout. Holds its last value between pulses.

## Operation
- **Accept.** A digit is accepted on a rising edge where digit_valid & digit_ready.
- **digit_ready** (combinational from registered state only; no path from digit_valid or bcd_ready):
  - IDLE: digit_ready = !g_n.
  - WAIT_UNITS: digit_ready = !g_n & !fifo_full.
- **FSM states: IDLE, WAIT_UNITS.**
- **IDLE, digit accepted:**
  - digit > 9: err pulse, err_code 01, stay in IDLE.
  - MAX_TENS < digit ≤ 9: err pulse, err_code 10, stay in IDLE.
  - otherwise: latch tens, clear the timeout counter, go to WAIT_UNITS.
- **WAIT_UNITS, digit accepted:**
  - digit > 9: err pulse, err_code 01, go to IDLE, nothing pushed.
  - otherwise: push {tens[1:0], digit} into the buffer, go to IDLE.
- **WAIT_UNITS, no digit accepted:** increment the timeout counter. The cycle the counter reaches TIMEOUT: err pulse, err_code 11, go to IDLE. A stall caused by a full buffer also counts toward timeout.
- **g_n high while in WAIT_UNITS:** return to IDLE silently, no err.
- **Error precedence:** code 01 over code 10.
- **Output buffer:** 2-entry FIFO.
  - pop on bcd_valid & bcd_ready.
  - push and pop in the same cycle are allowed. Occupancy is unchanged and order is preserved.
  - a push never occurs while full (guaranteed by digit_ready).
- **bcd_out** = head entry when bcd_valid is 1, 6'b000000 when the buffer is empty.

## Timing
- **Reset (async assert, sync release):**
  - state IDLE, buffer empty, timeout counter 0.
  - bcd_valid 0, bcd_out 0, err 0, err_code 00.
  - digit_ready follows !g_n from the first cycle after release.
- **Latency:** units digit accepted at edge N → bcd_valid = 1 with the new word after edge N (visible in cycle N+1), if the buffer was empty.
- **Throughput:** one word per 2 accepted digits. A new tens digit may be accepted the cycle after the units digit.
- **err** is registered: asserted for exactly the one cycle following the edge that detected the error.
- **Timeout:** with no digits arriving after the tens digit is accepted at edge T, err asserts after edge T+TIMEOUT.
- **Mid-operation reset:** any state or buffer content is discarded immediately, with no err pulse.

## Structure
- **Package bcd_entry_pkg:**
  - state enum {IDLE, WAIT_UNITS}
  - err codes ERR_DIGIT = 2'b01, ERR_TENS = 2'b10, ERR_TIMEOUT = 2'b11
  - BCD_MAX = 4'd9
- **Sub-module bcd_fifo2_cgrundey:**
  - 6-bit wide, 2-deep FIFO: push/pop, full/empty flags, registered head.
  - Same clk and rst_n as the parent.
- **Parent block:** FSM, range checks, timeout counter sized $clog2(TIMEOUT+1).

## Test plan
- **Basic packing:** digits 2, 7 with bcd_ready = 1 → bcd_out = 6'b10_0111 with bcd_valid high for one cycle; no err.
- **Invalid digit:** tens 4'hB → err pulse, err_code 01, remains IDLE. Tens 3, units 4'hC → err with code 01 and nothing pushed.
- **Tens out of range:** tens 5 with MAX_TENS = 3 → err with code 10. Then digits 3, 9 → bcd_out = 6'b11_1001.
- **Backpressure:** bcd_ready = 0 while entering 1,2 / 3,4 / 0,5.
  - Buffer holds 6'h12 and 6'h34.
  - digit_ready = 0 at the third units digit.
  - Releasing bcd_ready pops 12 then 34, then 05 is accepted.
  - With TIMEOUT = 15 and bcd_ready still low, err_code 11 after 15 stalled cycles.
- **Timeout and g_n:**
  - Tens 1, then idle for 15 cycles → err with code 11.
  - Tens 1, then g_n = 1 → silent return to IDLE, digit_ready = 0.
  - After g_n returns low, 0, 8 → bcd_out = 6'h08.
- **Reset:** assert rst_n low while in WAIT_UNITS with one buffered word → all outputs 0 immediately. After release, 3, 0 → bcd_out = 6'h30.

Source files
------------

// File: rtl/bcd_entry_cgrundey_pkg.sv
// Shared types and constants for the two-digit BCD entry stage.
package bcd_entry_pkg;

  typedef enum logic {
    IDLE       = 1'b0,
    WAIT_UNITS = 1'b1
  } state_e;

  localparam logic [1:0] ERR_DIGIT   = 2'b01;
  localparam logic [1:0] ERR_TENS    = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic [5:0] pack_bcd(input logic [1:0] tens, input logic [3:0] units);
    return {tens, units};
  endfunction

endpackage

// File: rtl/bcd_entry_cgrundey_if.sv
// Digit-entry and packed-word handshakes plus error reporting for bcd_entry_cgrundey.
interface bcd_entry_cgrundey_if;
  logic       g_n;
  logic [3:0] digit_in;
  logic       digit_valid;
  logic       digit_ready;
  logic [5:0] bcd_out;
  logic       bcd_valid;
  logic       bcd_ready;
  logic       err;
  logic [1:0] err_code;

  modport master (
    output g_n, digit_in, digit_valid, bcd_ready,
    input  digit_ready, bcd_out, bcd_valid, err, err_code
  );

  modport slave (
    input  g_n, digit_in, digit_valid, bcd_ready,
    output digit_ready, bcd_out, bcd_valid, err, err_code
  );
endinterface

// File: rtl/bcd_entry_cgrundey_fifo2.sv
// Two-deep, 6-bit FIFO with a registered head; unused slots are kept at zero so
// the head reads 6'b0 whenever the FIFO is empty.
module bcd_fifo2_cgrundey (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic [5:0] din,
  output logic       full,
  output logic       empty,
  output logic [5:0] head
);

  logic [5:0] mem0_q, mem0_d;
  logic [5:0] mem1_q, mem1_d;
  logic [1:0] cnt_q, cnt_d;
  logic       push_s;
  logic       pop_s;

  assign full   = (cnt_q == 2'd2);
  assign empty  = (cnt_q == 2'd0);
  assign head   = mem0_q;
  assign push_s = push & ~full;
  assign pop_s  = pop & ~empty;

  // Next-state for the two slots and the occupancy count
  always_comb begin
    mem0_d = mem0_q;
    mem1_d = mem1_q;
    cnt_d  = cnt_q;
    case ({push_s, pop_s})
      2'b10: begin
        if (cnt_q == 2'd0) begin
          mem0_d = din;
        end else begin
          mem1_d = din;
        end
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        mem0_d = mem1_q;
        mem1_d = 6'd0;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          mem0_d = din;
        end else begin
          mem0_d = mem1_q;
          mem1_d = din;
        end
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
  end

  // Slot and count registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem0_q <= 6'd0;
      mem1_q <= 6'd0;
      cnt_q  <= 2'd0;
    end else begin
      mem0_q <= mem0_d;
      mem1_q <= mem1_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/bcd_entry_cgrundey.sv
// Two-digit BCD entry: accepts tens then units, range-checks them, and queues
// packed {tens[1:0], units} words for the downstream BCD-to-binary converter.
module bcd_entry_cgrundey
  import bcd_entry_pkg::*;
#(
  parameter int unsigned MAX_TENS = 3,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bcd_entry_cgrundey_if.slave  bus
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT);
  localparam logic [3:0]       TENS_MAX = 4'(MAX_TENS);

  state_e           state_q, state_d;
  logic [1:0]       tens_q, tens_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [1:0]       err_code_q, err_code_d;

  logic             digit_ready_s;
  logic             accept_s;
  logic             push_s;
  logic             pop_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic [5:0]       fifo_head_s;
  logic [CNT_W-1:0] cnt_inc_s;

  // Ready depends only on registered state and g_n, never on digit_valid/bcd_ready
  assign digit_ready_s = ~bus.g_n & ((state_q == IDLE) | ~fifo_full_s);
  assign accept_s      = bus.digit_valid & digit_ready_s;
  assign pop_s         = ~fifo_empty_s & bus.bcd_ready;
  assign cnt_inc_s     = cnt_q + CNT_W'(1);

  // Entry FSM: range checks, packing and stall timeout
  always_comb begin
    state_d    = state_q;
    tens_d     = tens_q;
    cnt_d      = cnt_q;
    err_d      = 1'b0;
    err_code_d = err_code_q;
    push_s     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          if (bus.digit_in > BCD_MAX) begin
            err_d      = 1'b1;
            err_code_d = ERR_DIGIT;
          end else if (bus.digit_in > TENS_MAX) begin
            err_d      = 1'b1;
            err_code_d = ERR_TENS;
          end else begin
            tens_d  = bus.digit_in[1:0];
            cnt_d   = '0;
            state_d = WAIT_UNITS;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_UNITS: begin
        if (bus.g_n) begin
          state_d = IDLE;
        end else if (accept_s) begin
          if (bus.digit_in > BCD_MAX) begin
            err_d      = 1'b1;
            err_code_d = ERR_DIGIT;
          end else begin
            push_s = 1'b1;
          end
          state_d = IDLE;
        end else begin
          // Stalls on a full buffer count toward the timeout as well
          cnt_d = cnt_inc_s;
          if (cnt_inc_s == CNT_LAST) begin
            err_d      = 1'b1;
            err_code_d = ERR_TIMEOUT;
            state_d    = IDLE;
          end else begin
            state_d = WAIT_UNITS;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM, tens latch, timeout counter and error registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tens_q     <= 2'd0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      tens_q     <= tens_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  bcd_fifo2_cgrundey u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .pop   (pop_s),
    .din   (pack_bcd(tens_q, bus.digit_in)),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .head  (fifo_head_s)
  );

  assign bus.digit_ready = digit_ready_s;
  assign bus.bcd_out     = fifo_head_s;
  assign bus.bcd_valid   = ~fifo_empty_s;
  assign bus.err         = err_q;
  assign bus.err_code    = err_code_q;

endmodule

// File: tb/tb_bcd_entry_cgrundey.sv
// Scoreboard bench for bcd_entry_cgrundey: directed test-plan sequences followed
// by random digit traffic, checked against a queue-based reference model.
module tb_bcd_entry_cgrundey;

  localparam int MAX_TENS = 3;
  localparam int TIMEOUT  = 15;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bcd_entry_cgrundey_if bus ();

  bcd_entry_cgrundey #(.MAX_TENS(MAX_TENS), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // reference model state
  bit         m_wait = 1'b0;
  int         m_tens = 0;
  int         m_cnt  = 0;
  logic [5:0] m_fifo[$];
  logic       m_err  = 1'b0;
  logic [1:0] m_code = 2'b00;

  // scoreboard queues
  logic [5:0] exp_words[$];
  logic [1:0] exp_errs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_ready();
    return !bus.g_n && (!m_wait || m_fifo.size() < 2);
  endfunction

  task automatic model_reset();
    m_wait = 1'b0;
    m_cnt  = 0;
    m_err  = 1'b0;
    m_code = 2'b00;
    m_fifo.delete();
    exp_words.delete();
    exp_errs.delete();
  endtask

  task automatic model_step();
    bit         rdy;
    bit         acc;
    int         d;
    bit         e;
    logic [1:0] c;
    logic [5:0] w;
    rdy = model_ready();
    acc = bus.digit_valid && rdy;
    d   = int'(bus.digit_in);
    e   = 1'b0;
    c   = 2'b00;
    if (m_fifo.size() > 0 && bus.bcd_ready) void'(m_fifo.pop_front());
    if (!m_wait) begin
      if (acc) begin
        if (d > 9) begin
          e = 1'b1; c = 2'b01;
        end else if (d > MAX_TENS) begin
          e = 1'b1; c = 2'b10;
        end else begin
          m_tens = d;
          m_cnt  = 0;
          m_wait = 1'b1;
        end
      end
    end else if (bus.g_n) begin
      m_wait = 1'b0;
    end else if (acc) begin
      if (d > 9) begin
        e = 1'b1; c = 2'b01;
      end else begin
        w = 6'(m_tens * 16 + d);
        m_fifo.push_back(w);
        exp_words.push_back(w);
      end
      m_wait = 1'b0;
    end else begin
      m_cnt++;
      if (m_cnt >= TIMEOUT) begin
        e = 1'b1; c = 2'b11;
        m_wait = 1'b0;
      end
    end
    m_err = e;
    if (e) begin
      m_code = c;
      exp_errs.push_back(c);
    end
  endtask

  // model advances on every active edge and clears on reset assertion
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // monitor: compares outputs on the falling edge and drains the scoreboard
  initial begin
    logic [5:0] head;
    logic [5:0] w;
    logic [1:0] c;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_bcd_valid", bus.bcd_valid, 1'b0);
        check("rst_bcd_out", bus.bcd_out, 6'd0);
        check("rst_err", bus.err, 1'b0);
        check("rst_err_code", bus.err_code, 2'b00);
      end else begin
        head = (m_fifo.size() > 0) ? m_fifo[0] : 6'd0;
        check("digit_ready", bus.digit_ready, model_ready());
        check("bcd_valid", bus.bcd_valid, m_fifo.size() > 0);
        check("bcd_out", bus.bcd_out, head);
        check("err", bus.err, m_err);
        check("err_code", bus.err_code, m_code);
        if (bus.bcd_valid && bus.bcd_ready) begin
          if (exp_words.size() == 0) begin
            check("word_unexpected", bus.bcd_out, 32'hFFFF_FFFF);
          end else begin
            w = exp_words.pop_front();
            check("word_sb", bus.bcd_out, w);
          end
        end
        if (bus.err) begin
          if (exp_errs.size() == 0) begin
            check("err_unexpected", bus.err_code, 32'hFFFF_FFFF);
          end else begin
            c = exp_errs.pop_front();
            check("err_sb", bus.err_code, c);
          end
        end
      end
    end
  end

  task automatic tick(input logic v, input logic [3:0] d, input logic br, input logic g);
    bus.digit_valid = v;
    bus.digit_in    = d;
    bus.bcd_ready   = br;
    bus.g_n         = g;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] rand_digit();
    if ($urandom_range(0, 9) == 0) return 4'($urandom_range(10, 15));
    return 4'($urandom_range(0, 9));
  endfunction

  initial begin
    bus.g_n         = 1'b0;
    bus.digit_valid = 1'b0;
    bus.digit_in    = 4'd0;
    bus.bcd_ready   = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // basic packing 2,7
    tick(1'b1, 4'd2, 1'b1, 1'b0); tick(1'b1, 4'd7, 1'b1, 1'b0);
    tick(1'b0, 4'd0, 1'b1, 1'b0); tick(1'b0, 4'd0, 1'b1, 1'b0);
    // invalid digits
    tick(1'b1, 4'hB, 1'b1, 1'b0); tick(1'b0, 4'd0, 1'b1, 1'b0);
    tick(1'b1, 4'd3, 1'b1, 1'b0); tick(1'b1, 4'hC, 1'b1, 1'b0);
    tick(1'b0, 4'd0, 1'b1, 1'b0);
    // tens out of range, then 3,9
    tick(1'b1, 4'd5, 1'b1, 1'b0); tick(1'b1, 4'd3, 1'b1, 1'b0);
    tick(1'b1, 4'd9, 1'b1, 1'b0); tick(1'b0, 4'd0, 1'b1, 1'b0);
    tick(1'b0, 4'd0, 1'b1, 1'b0);
    // backpressure 1,2 / 3,4 / 0,5 and stall timeout
    tick(1'b1, 4'd1, 1'b0, 1'b0); tick(1'b1, 4'd2, 1'b0, 1'b0);
    tick(1'b1, 4'd3, 1'b0, 1'b0); tick(1'b1, 4'd4, 1'b0, 1'b0);
    tick(1'b1, 4'd0, 1'b0, 1'b0);
    repeat (15) tick(1'b1, 4'd5, 1'b0, 1'b0);
    tick(1'b0, 4'd0, 1'b0, 1'b0);
    tick(1'b1, 4'd0, 1'b1, 1'b0); tick(1'b1, 4'd5, 1'b1, 1'b0);
    repeat (3) tick(1'b0, 4'd0, 1'b1, 1'b0);
    // idle timeout after tens
    tick(1'b1, 4'd1, 1'b1, 1'b0);
    repeat (16) tick(1'b0, 4'd0, 1'b1, 1'b0);
    // g_n flush, then 0,8
    tick(1'b1, 4'd1, 1'b1, 1'b0); tick(1'b0, 4'd0, 1'b1, 1'b1);
    tick(1'b1, 4'd8, 1'b1, 1'b1); tick(1'b0, 4'd0, 1'b1, 1'b0);
    tick(1'b1, 4'd0, 1'b1, 1'b0); tick(1'b1, 4'd8, 1'b1, 1'b0);
    repeat (2) tick(1'b0, 4'd0, 1'b1, 1'b0);
    // reset while in WAIT_UNITS with one buffered word
    tick(1'b1, 4'd3, 1'b0, 1'b0); tick(1'b1, 4'd0, 1'b0, 1'b0);
    tick(1'b1, 4'd2, 1'b0, 1'b0);
    bus.digit_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", bus.bcd_valid, 1'b0);
    check("async_rst_out", bus.bcd_out, 6'd0);
    check("async_rst_err", bus.err, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick(1'b1, 4'd3, 1'b1, 1'b0); tick(1'b1, 4'd0, 1'b1, 1'b0);
    repeat (2) tick(1'b0, 4'd0, 1'b1, 1'b0);

    // random traffic with occasional long idle stretches
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        repeat (18) tick(1'b0, 4'd0, 1'($urandom_range(0, 1)), 1'b0);
      end else begin
        tick(1'($urandom_range(0, 3) != 0), rand_digit(),
             1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
      end
    end

    repeat (5) tick(1'b0, 4'd0, 1'b1, 1'b0);
    check("words_left", exp_words.size(), 32'd0);
    check("errs_left", exp_errs.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
